// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock timekeeping core: mode encoding,
// default rates and the packed-BCD increment-with-limit helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam int PRESCALE_DEF = 500;
  localparam int DEBOUNCE_DEF = 10;

  localparam logic [7:0] BCD_MAX_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_HR  = 8'h23;

  // True when the next increment must wrap the field back to 00.
  function automatic logic bcd_wraps(input logic [7:0] value, input logic [7:0] limit);
    return value >= limit;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
    if (bcd_wraps(value, limit)) return 8'h00;
    if (value[3:0] >= 4'd9)      return {value[7:4] + 4'd1, 4'd0};
    return {value[7:4], value[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/key_filter.sv
// Push-button conditioner: 2-FF synchronizer, stable-level debounce filter
// and a one-cycle pulse on the rising edge of the filtered level.
module key_filter
  import clock_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic _500Hz,
  input  logic rst,
  input  logic key_raw,
  output logic key_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync_1;
  logic          sync_2;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge _500Hz or posedge rst) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      cnt       <= '0;
      key_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples pre-edge values; the
      // synchronizer chain and the edge detector depend on that ordering.
      sync_1    <= key_raw;
      sync_2    <= sync_1;
      stable_d  <= stable;
      key_pulse <= stable & ~stable_d;
      // cnt holds how many consecutive samples already disagree with stable.
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_core.sv
// Timekeeping core: 1 Hz prescaler, BCD HH:MM:SS (24 h) and a three-state
// mode FSM that lets two buttons set hours and minutes.
module time_core
  import clock_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic       _500Hz,
  input  logic       rst,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic [7:0] Hr,
  output logic [7:0] Min,
  output logic [7:0] Sec,
  output logic       _1Hz,
  output logic [1:0] mode
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(PRESCALE / 2);

  mode_t         state;
  mode_t         state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [7:0]    hr_next;
  logic [7:0]    min_next;
  logic [7:0]    sec_next;
  logic          one_hz_next;
  logic          tick;
  logic          mode_p;
  logic          inc_p;

  key_filter #(.DEBOUNCE(DEBOUNCE)) u_mode_key (
    ._500Hz   (_500Hz),
    .rst      (rst),
    .key_raw  (mode_key),
    .key_pulse(mode_p)
  );

  key_filter #(.DEBOUNCE(DEBOUNCE)) u_inc_key (
    ._500Hz   (_500Hz),
    .rst      (rst),
    .key_raw  (inc_key),
    .key_pulse(inc_p)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    state_next = state;
    presc_next = presc;
    hr_next    = Hr;
    min_next   = Min;
    sec_next   = Sec;
    tick       = 1'b0;

    unique case (state)
      RUN: begin
        tick       = (presc == PRE_LAST);
        presc_next = tick ? '0 : presc + 1'b1;
        // The whole carry chain resolves here, so 23:59:59 rolls in one edge.
        if (tick) begin
          sec_next = bcd_inc(Sec, BCD_MAX_MIN);
          if (bcd_wraps(Sec, BCD_MAX_MIN)) begin
            min_next = bcd_inc(Min, BCD_MAX_MIN);
            if (bcd_wraps(Min, BCD_MAX_MIN)) hr_next = bcd_inc(Hr, BCD_MAX_HR);
          end
        end
        if (mode_p) state_next = SET_HR;
      end
      SET_HR: begin
        if (mode_p)     state_next = SET_MIN;
        else if (inc_p) hr_next    = bcd_inc(Hr, BCD_MAX_HR);
      end
      SET_MIN: begin
        // Leaving set mode restarts the second from a clean prescaler phase.
        if (mode_p) begin
          state_next = RUN;
          sec_next   = 8'h00;
          presc_next = '0;
        end else if (inc_p) begin
          min_next = bcd_inc(Min, BCD_MAX_MIN);
        end
      end
      default: state_next = RUN;
    endcase

    one_hz_next = (state == RUN) && (state_next == RUN) && (presc_next < PRE_HALF);
  end

  always_ff @(posedge _500Hz or posedge rst) begin
    if (rst) begin
      state <= RUN;
      presc <= '0;
      Hr    <= 8'h00;
      Min   <= 8'h00;
      Sec   <= 8'h00;
      _1Hz  <= 1'b0;
    end else begin
      state <= state_next;
      presc <= presc_next;
      Hr    <= hr_next;
      Min   <= min_next;
      Sec   <= sec_next;
      _1Hz  <= one_hz_next;
    end
  end

  assign mode = state;

endmodule
